// File: rtl/handle_tracker.sv
// handle_tracker: per-frame centroid and pixel-count tracking of two colour markers,
// using a shared serial restoring divider with a fixed 121-cycle latency.
module handle_tracker #(
    parameter int MIN_PIXELS  = 16,
    parameter int LOST_FRAMES = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        pix_valid,
    input  logic        top_match,
    input  logic        bottom_match,
    input  logic        frame_end,
    output logic [10:0] handle_top_x,
    output logic [9:0]  handle_top_y,
    output logic [10:0] handle_top_z,
    output logic [10:0] handle_bottom_x,
    output logic [9:0]  handle_bottom_y,
    output logic [10:0] handle_bottom_z,
    output logic        coords_valid,
    output logic        busy,
    output logic        tracking_lost
);
    localparam int MW = $clog2(LOST_FRAMES + 1);
    localparam logic [MW-1:0] LOST = MW'(LOST_FRAMES);
    localparam logic [19:0] MINP = 20'(MIN_PIXELS);

    typedef enum logic [1:0] {IDLE, DIV, UPDATE} state_t;
    state_t state, state_nx;

    logic [29:0] top_sx, bot_sx, snap_tsx, snap_bsx;
    logic [28:0] top_sy, bot_sy, snap_tsy, snap_bsy;
    logic [19:0] top_cnt, bot_cnt, snap_tc, snap_bc;
    logic [4:0]  bit_idx;
    logic [1:0]  slot;
    logic [29:0] dq, dividend, cur_dq, dq_nx;
    logic [19:0] rem, cur_rem, divisor, rem_nx;
    logic [20:0] shifted;
    logic [10:0] q_tx, q_bx, z_t, z_b;
    logic [9:0]  q_ty, q_by;
    logic [MW-1:0] top_miss, bot_miss, top_miss_nx, bot_miss_nx;
    logic top_found, bot_found, start, update, last_step, step_en, qbit;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (frame_end ? DIV : IDLE) :
                   (state == DIV)  ? ((slot == 2'd3 && last_step) ? UPDATE : DIV) : IDLE;

    always_comb begin
        busy   = state != IDLE;
        update = state == UPDATE;
        start  = state == IDLE && frame_end;
    end

    // A frame_end always empties the accumulators; only an idle one snapshots them.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            top_sx  <= '0;
            top_sy  <= '0;
            top_cnt <= '0;
            bot_sx  <= '0;
            bot_sy  <= '0;
            bot_cnt <= '0;
        end else if (frame_end) begin
            top_sx  <= '0;
            top_sy  <= '0;
            top_cnt <= '0;
            bot_sx  <= '0;
            bot_sy  <= '0;
            bot_cnt <= '0;
        end else begin
            if (pix_valid && top_match) begin
                top_sx  <= top_sx + 30'(hcount);
                top_sy  <= top_sy + 29'(vcount);
                top_cnt <= top_cnt + 20'd1;
            end
            if (pix_valid && bottom_match) begin
                bot_sx  <= bot_sx + 30'(hcount);
                bot_sy  <= bot_sy + 29'(vcount);
                bot_cnt <= bot_cnt + 20'd1;
            end
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            snap_tsx <= '0;
            snap_tsy <= '0;
            snap_tc  <= '0;
            snap_bsx <= '0;
            snap_bsy <= '0;
            snap_bc  <= '0;
        end else if (start) begin
            snap_tsx <= top_sx;
            snap_tsy <= top_sy;
            snap_tc  <= top_cnt;
            snap_bsx <= bot_sx;
            snap_bsy <= bot_sy;
            snap_bc  <= bot_cnt;
        end

    always_comb begin
        top_found = snap_tc >= MINP;
        bot_found = snap_bc >= MINP;
        last_step = bit_idx == 5'd29;
        dividend  = (slot == 2'd0) ? snap_tsx : (slot == 2'd1) ? {1'b0, snap_tsy} :
                    (slot == 2'd2) ? snap_bsx : {1'b0, snap_bsy};
        divisor   = slot[1] ? snap_bc : snap_tc;
        step_en   = slot[1] ? bot_found : top_found;
        cur_dq    = (bit_idx == 5'd0) ? dividend : dq;
        cur_rem   = (bit_idx == 5'd0) ? 20'd0 : rem;
        shifted   = {cur_rem, cur_dq[29]};
        qbit      = shifted >= {1'b0, divisor};
        rem_nx    = qbit ? shifted[19:0] - divisor : shifted[19:0];
        dq_nx     = {cur_dq[28:0], qbit};
    end

    // Each 30-cycle slot yields one quotient; slots of a missed marker idle.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            bit_idx <= '0;
            slot    <= '0;
            dq      <= '0;
            rem     <= '0;
            q_tx    <= '0;
            q_ty    <= '0;
            q_bx    <= '0;
            q_by    <= '0;
        end else if (state == DIV) begin
            bit_idx <= last_step ? 5'd0 : bit_idx + 5'd1;
            if (last_step)
                slot <= slot + 2'd1;
            if (step_en) begin
                dq  <= dq_nx;
                rem <= rem_nx;
            end
            if (step_en && last_step) begin
                if (slot == 2'd0) q_tx <= dq_nx[10:0];
                if (slot == 2'd1) q_ty <= dq_nx[9:0];
                if (slot == 2'd2) q_bx <= dq_nx[10:0];
                if (slot == 2'd3) q_by <= dq_nx[9:0];
            end
        end

    always_comb begin
        z_t         = |snap_tc[19:11] ? 11'd2047 : snap_tc[10:0];
        z_b         = |snap_bc[19:11] ? 11'd2047 : snap_bc[10:0];
        top_miss_nx = top_found ? '0 : (top_miss == LOST) ? LOST : top_miss + 1'b1;
        bot_miss_nx = bot_found ? '0 : (bot_miss == LOST) ? LOST : bot_miss + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            handle_top_x    <= '0;
            handle_top_y    <= '0;
            handle_top_z    <= '0;
            handle_bottom_x <= '0;
            handle_bottom_y <= '0;
            handle_bottom_z <= '0;
            top_miss        <= LOST;
            bot_miss        <= LOST;
            tracking_lost   <= 1'b1;
            coords_valid    <= 1'b0;
        end else begin
            coords_valid <= update;
            if (update) begin
                top_miss      <= top_miss_nx;
                bot_miss      <= bot_miss_nx;
                tracking_lost <= (top_miss_nx == LOST) || (bot_miss_nx == LOST);
                if (top_found) begin
                    handle_top_x <= q_tx;
                    handle_top_y <= q_ty;
                    handle_top_z <= z_t;
                end
                if (bot_found) begin
                    handle_bottom_x <= q_bx;
                    handle_bottom_y <= q_by;
                    handle_bottom_z <= z_b;
                end
            end
        end
endmodule

// File: tb/tb_handle_tracker.sv
// tb_handle_tracker: randomized frames checked against a centroid model built from
// plain sums, integer division and miss counting.
module tb_handle_tracker;
    localparam int MIN_PIXELS  = 16;
    localparam int LOST_FRAMES = 8;

    logic        clock = 0, reset_n = 0;
    logic [10:0] hcount = 0;
    logic [9:0]  vcount = 0;
    logic        pix_valid = 0, top_match = 0, bottom_match = 0, frame_end = 0;
    logic [10:0] handle_top_x, handle_top_z, handle_bottom_x, handle_bottom_z;
    logic [9:0]  handle_top_y, handle_bottom_y;
    logic        coords_valid, busy, tracking_lost;

    int checks = 0, errors = 0;
    longint at_sx, at_sy, at_c, ab_sx, ab_sy, ab_c;
    longint st_sx, st_sy, st_c, sb_sx, sb_sy, sb_c;
    int e_tx, e_ty, e_tz, e_bx, e_by, e_bz, miss_t, miss_b;
    bit e_lost;

    handle_tracker #(.MIN_PIXELS(MIN_PIXELS), .LOST_FRAMES(LOST_FRAMES)) dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .pix_valid(pix_valid), .top_match(top_match), .bottom_match(bottom_match),
        .frame_end(frame_end), .handle_top_x(handle_top_x), .handle_top_y(handle_top_y),
        .handle_top_z(handle_top_z), .handle_bottom_x(handle_bottom_x),
        .handle_bottom_y(handle_bottom_y), .handle_bottom_z(handle_bottom_z),
        .coords_valid(coords_valid), .busy(busy), .tracking_lost(tracking_lost)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_acc;
        at_sx = 0; at_sy = 0; at_c = 0; ab_sx = 0; ab_sy = 0; ab_c = 0;
    endtask

    task automatic model_reset;
        clear_acc();
        e_tx = 0; e_ty = 0; e_tz = 0; e_bx = 0; e_by = 0; e_bz = 0;
        miss_t = LOST_FRAMES; miss_b = LOST_FRAMES; e_lost = 1;
    endtask

    task automatic idle_in;
        pix_valid = 0; top_match = 0; bottom_match = 0; frame_end = 0;
    endtask

    task automatic set_pix(input int x, input int y, input bit pv, input bit t, input bit b,
                           input bit keep);
        hcount = 11'(x); vcount = 10'(y); pix_valid = pv; top_match = t; bottom_match = b;
        if (keep && pv && t) begin at_sx += x; at_sy += y; at_c++; end
        if (keep && pv && b) begin ab_sx += x; ab_sy += y; ab_c++; end
    endtask

    task automatic rand_pix(input bit keep);
        int x, y;
        bit pv, t, b;
        x = $urandom_range(0, 2047); y = $urandom_range(0, 1023);
        pv = $urandom_range(0, 3) != 0;
        t = $urandom_range(0, 7) == 0;
        b = $urandom_range(0, 7) == 0;
        set_pix(x, y, pv, t, b, keep);
    endtask

    task automatic block(input int x0, input int y0, input int w, input int h,
                         input bit t, input bit b);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++) begin
                set_pix(x0 + xx, y0 + yy, 1, t, b, 1);
                tick();
                idle_in();
            end
    endtask

    // The matched pixel coinciding with frame_end must be discarded.
    task automatic start_frame;
        frame_end = 1;
        set_pix($urandom_range(0, 2047), $urandom_range(0, 1023), 1, 1, 1, 0);
        st_sx = at_sx; st_sy = at_sy; st_c = at_c;
        sb_sx = ab_sx; sb_sy = ab_sy; sb_c = ab_c;
        clear_acc();
        tick();
        idle_in();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_edge0: busy=%b required 1", busy);
        end
    endtask

    task automatic model_update;
        if (st_c >= MIN_PIXELS) begin
            e_tx = int'(st_sx / st_c); e_ty = int'(st_sy / st_c);
            e_tz = st_c > 2047 ? 2047 : int'(st_c); miss_t = 0;
        end else if (miss_t < LOST_FRAMES) miss_t++;
        if (sb_c >= MIN_PIXELS) begin
            e_bx = int'(sb_sx / sb_c); e_by = int'(sb_sy / sb_c);
            e_bz = sb_c > 2047 ? 2047 : int'(sb_c); miss_b = 0;
        end else if (miss_b < LOST_FRAMES) miss_b++;
        e_lost = (miss_t == LOST_FRAMES) || (miss_b == LOST_FRAMES);
    endtask

    task automatic finish_frame(input int ovr, input bit noise);
        for (int i = 1; i <= 121; i++) begin
            if (i == ovr) begin
                frame_end = 1;
                rand_pix(0);
                clear_acc();
            end else if (noise) rand_pix(1);
            tick();
            idle_in();
            if (i < 121) begin
                checks++;
                if (busy !== 1'b1 || coords_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_window edge %0d: busy=%b coords_valid=%b required 1,0",
                             i, busy, coords_valid);
                end
            end
        end
        model_update();
        checks++;
        if (coords_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL edge121_flags: coords_valid=%b busy=%b required 1,0", coords_valid, busy);
        end
        checks++;
        if (handle_top_x !== 11'(e_tx) || handle_top_y !== 10'(e_ty) || handle_top_z !== 11'(e_tz)) begin
            errors++;
            $display("FAIL top_coords: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     handle_top_x, handle_top_y, handle_top_z, e_tx, e_ty, e_tz);
        end
        checks++;
        if (handle_bottom_x !== 11'(e_bx) || handle_bottom_y !== 10'(e_by) ||
            handle_bottom_z !== 11'(e_bz)) begin
            errors++;
            $display("FAIL bottom_coords: got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     handle_bottom_x, handle_bottom_y, handle_bottom_z, e_bx, e_by, e_bz);
        end
        checks++;
        if (tracking_lost !== e_lost) begin
            errors++;
            $display("FAIL tracking_lost: got %b required %b", tracking_lost, e_lost);
        end
        tick();
        checks++;
        if (coords_valid !== 1'b0) begin
            errors++;
            $display("FAIL coords_valid_pulse: got %b required 0 one cycle later", coords_valid);
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (handle_top_x !== 0 || handle_top_y !== 0 || handle_top_z !== 0 ||
            handle_bottom_x !== 0 || handle_bottom_y !== 0 || handle_bottom_z !== 0) begin
            errors++;
            $display("FAIL %s_coords: got (%0d,%0d,%0d)(%0d,%0d,%0d) required all 0", tag,
                     handle_top_x, handle_top_y, handle_top_z,
                     handle_bottom_x, handle_bottom_y, handle_bottom_z);
        end
        checks++;
        if (coords_valid !== 1'b0 || busy !== 1'b0 || tracking_lost !== 1'b1) begin
            errors++;
            $display("FAIL %s_flags: coords_valid=%b busy=%b lost=%b required 0,0,1", tag,
                     coords_valid, busy, tracking_lost);
        end
    endtask

    task automatic test_reset;
        model_reset();
        idle_in();
        reset_n = 0;
        repeat (3) tick();
        check_reset_state("reset");
        reset_n = 1;
    endtask

    task automatic test_normal;
        block(100, 200, 4, 4, 1, 0);
        block(300, 400, 4, 4, 0, 1);
        start_frame();
        finish_frame(-1, 0);
        checks++;
        if (handle_top_x !== 11'd101 || handle_top_y !== 10'd201 || handle_top_z !== 11'd16 ||
            handle_bottom_x !== 11'd301 || handle_bottom_y !== 10'd401 ||
            handle_bottom_z !== 11'd16 || tracking_lost !== 1'b0) begin
            errors++;
            $display("FAIL normal_literal: top (%0d,%0d,%0d) bottom (%0d,%0d,%0d) lost %b required (101,201,16) (301,401,16) 0",
                     handle_top_x, handle_top_y, handle_top_z, handle_bottom_x,
                     handle_bottom_y, handle_bottom_z, tracking_lost);
        end
    endtask

    task automatic test_loss;
        for (int f = 0; f < 8; f++) begin
            block($urandom_range(0, 2000), $urandom_range(0, 1000), 4, 4, 1, 0);
            block(500, 600, 15, 1, 0, 1);
            start_frame();
            finish_frame(-1, 0);
        end
        checks++;
        if (handle_bottom_x !== 11'd301 || handle_bottom_y !== 10'd401 ||
            handle_bottom_z !== 11'd16 || tracking_lost !== 1'b1) begin
            errors++;
            $display("FAIL loss_hold: bottom (%0d,%0d,%0d) lost %b required (301,401,16) 1",
                     handle_bottom_x, handle_bottom_y, handle_bottom_z, tracking_lost);
        end
        block(700, 800, 4, 4, 0, 1);
        start_frame();
        finish_frame(-1, 0);
        checks++;
        if (tracking_lost !== 1'b0) begin
            errors++;
            $display("FAIL loss_recover: lost %b required 0", tracking_lost);
        end
    endtask

    task automatic test_overrun;
        block($urandom_range(0, 2000), $urandom_range(0, 1000), 5, 4, 1, 1);
        start_frame();
        finish_frame(50, 1);
        block($urandom_range(0, 2000), $urandom_range(0, 1000), 4, 5, 1, 0);
        block($urandom_range(0, 2000), $urandom_range(0, 1000), 6, 3, 0, 1);
        start_frame();
        finish_frame(-1, 0);
    endtask

    task automatic test_reset_mid;
        block(40, 50, 4, 4, 1, 1);
        start_frame();
        repeat (60) tick();
        reset_n = 0;
        #1;
        model_reset();
        check_reset_state("reset_mid");
        tick();
        reset_n = 1;
        for (int i = 0; i < 130; i++) begin
            tick();
            checks++;
            if (coords_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet cycle %0d: coords_valid=%b busy=%b required 0,0",
                         i, coords_valid, busy);
            end
        end
    endtask

    task automatic test_zsat;
        for (int r = 0; r < 3; r++) block(0, 10 + r, 1000, 1, 1, 0);
        start_frame();
        finish_frame(-1, 0);
        checks++;
        if (handle_top_z !== 11'd2047 || handle_top_x !== 11'd499 || handle_top_y !== 10'd11) begin
            errors++;
            $display("FAIL zsat_literal: top (%0d,%0d,%0d) required (499,11,2047)",
                     handle_top_x, handle_top_y, handle_top_z);
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) != 0)
                block($urandom_range(0, 2040), $urandom_range(0, 1016),
                      $urandom_range(3, 5), $urandom_range(3, 5), 1, 0);
            if ($urandom_range(0, 3) != 0)
                block($urandom_range(0, 2040), $urandom_range(0, 1016),
                      $urandom_range(3, 5), $urandom_range(3, 5), 0, 1);
            start_frame();
            finish_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 121)) : -1, 1);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_loss();
        test_overrun();
        test_reset_mid();
        test_zsat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
